shift_pipe: RTL
===============

Name: shift_pipe

Overview:
- Parametrised, pipelined successor to the combinational ARM barrel shifter.
- Performs LSL/LSR/ASR/ROR/RRX on a DATA_W operand with a register-specified shift amount, under full ARM carry-out semantics, including amounts >= DATA_W.
- Sits between operand fetch and the ALU in the execute stage; valid/ready handshakes on both sides, a tag passthrough, and a synchronous flush for branch/exception kill.

Parameters:
- DATA_W, 32, operand/result width; power of two, 8..64.
- AMT_W, 8, shift-amount width; must satisfy 2**AMT_W > DATA_W.
- TAG_W, 4, width of sideband tag carried alongside each operation.
- PIPE, 2, pipeline depth; legal values 1 or 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept input this cycle.
- in_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_rrx  in  1  1 = RRX; overrides in_type and in_amt.
- in_amt  in  AMT_W  unsigned shift amount.
- in_op  in  DATA_W  operand.
- in_carry  in  1  current C flag.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  shifted value.
- out_carry  out  1  shifter carry-out.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: all stage valid bits, out_valid, out_result, out_carry and out_tag are 0. in_ready is 1 one cycle after rst_n deasserts.
- Handshake:
  - Transfer occurs when valid && ready.
  - Each stage k: ready_k = !valid_k || ready_(k+1); the last stage uses out_ready.
  - in_ready = ready_0, combinational from out_ready.
  - Throughput 1 op/cycle; latency PIPE cycles from input transfer to out_valid.
  - Outputs hold stable while out_valid && !out_ready.
- Pipeline split (results are identical for PIPE=1 and PIPE=2):
  - PIPE=1: the whole operation is computed in one registered stage.
  - PIPE=2: stage 1 classifies the amount (zero / < DATA_W / == DATA_W / > DATA_W) and applies the coarse shift by amt[log2(DATA_W)-1 : log2(DATA_W)/2]. Stage 2 applies the fine shift and selects the carry.
- Semantics (W = DATA_W, a = in_amt):
  - a == 0, any type, rrx=0: result = op, carry = in_carry.
  - LSL, 1 <= a < W: op << a, carry = op[W-a]. a == W: 0, carry op[0]. a > W: 0, carry 0.
  - LSR, 1 <= a < W: op >> a, carry = op[a-1]. a == W: 0, carry op[W-1]. a > W: 0, carry 0.
  - ASR, 1 <= a < W: arithmetic shift, carry = op[a-1]. a >= W: all bits op[W-1], carry op[W-1].
  - ROR, a mod W != 0: rotate right by a mod W, carry = result[W-1]. a != 0 and a mod W == 0: result = op, carry = op[W-1].
  - RRX: result = {in_carry, op[W-1:1]}, carry = op[0].
- Flush:
  - Clears every stage valid bit at the next edge. Input presented in the same cycle is dropped; in_ready may still read 1.
  - Flush while out_valid && !out_ready discards that result.
- Simultaneous events: flush overrides any transfer in the same cycle.
- Reset mid-operation: all in-flight operations are lost; no partial output.

Optional Feature:
- Macro SHIFT_IMM_DECODE_EN.
- When defined:
  - Adds input port in_imm (1 bit) that travels with each operation.
  - When in_imm = 1 and amt[4:0] == 0, the immediate encoding applies: LSL means no shift (carry = in_carry); LSR means LSR #W; ASR means ASR #W; ROR means RRX.
  - When in_imm = 1, amt bits above [4:0] are ignored.
- When undefined: the in_imm port is absent and only register-specified semantics apply.

Test Plan:
- W=32, LSL, op=0x8000_0001, amt=1, carry_in=0 -> result 0x0000_0002, carry 1, out_valid 2 cycles after transfer (PIPE=2).
- LSR amt=32, op=0x8000_0000 -> result 0, carry 1. Same with amt=33 -> result 0, carry 0.
- ASR amt=40, op=0x9000_0000 -> result 0xFFFF_FFFF, carry 1. ROR amt=64, op=0x8000_0001 -> result 0x8000_0001, carry 1. RRX op=0x0000_0003, carry_in=1 -> result 0x8000_0001, carry 1.
- Backpressure: 4 back-to-back ops with out_ready held 0 for 3 cycles -> in_ready drops after the pipe fills, no op lost or duplicated, tags exit in order 0,1,2,3.
- Flush asserted with 2 ops in flight and 1 presented -> no out_valid on the following cycles; the next op after flush completes normally with the correct tag.
- Reset asserted asynchronously mid-stream -> out_valid = 0 immediately. With SHIFT_IMM_DECODE_EN: in_imm=1, ROR, amt=0, op=0x2, carry_in=1 -> result 0x8000_0001, carry 0.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe -- pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX).
//
// Computes the shifted operand and the shifter carry-out under full ARM
// semantics, including shift amounts of DATA_W and above. It sits between
// operand fetch and the ALU, with valid/ready on both sides, a sideband tag
// that travels with each operation, and a synchronous flush.
//
// Optional feature: define SHIFT_IMM_DECODE_EN to add the in_imm port. With
// in_imm = 1 the amount is taken from amt[4:0] only, and amt[4:0] == 0 selects
// the immediate special encodings (LSL #0, LSR #W, ASR #W, RRX).
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   flush          synchronous kill of every in-flight operation
//   in_valid/ready input handshake; in_ready is combinational from out_ready
//   in_type        00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_rrx         1 = RRX, overrides in_type and in_amt
//   in_amt         unsigned shift amount
//   in_op          operand
//   in_carry       current C flag
//   in_tag         sideband tag
//   in_imm         (SHIFT_IMM_DECODE_EN only) immediate-encoded amount
//   out_valid/ready output handshake
//   out_result     shifted value
//   out_carry      shifter carry-out
//   out_tag        tag of the result
//
// Handshake: a transfer happens on a rising edge where valid && ready. A stage
// is ready when it is empty or the stage after it is ready; the last stage
// uses out_ready. Outputs hold while out_valid && !out_ready. Flush clears all
// stage valid bits at the next edge and wins over any transfer in that cycle.
module shift_pipe #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8,
    parameter int TAG_W  = 4,
    parameter int PIPE   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic              in_rrx,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [DATA_W-1:0] in_op,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef SHIFT_IMM_DECODE_EN
    input  logic              in_imm,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LW = $clog2(DATA_W);
    localparam int FW = LW / 2;          // fine-shift amount bits
    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;
    localparam logic [AMT_W-1:0] AMT_FULL = AMT_W'(DATA_W);

    // State carried from the coarse stage to the fine stage.
    // coarse is one bit wider than the operand: for LSL the extra top bit
    // catches the last bit shifted out, for LSR/ASR the extra bottom bit does,
    // so the carry falls out of the same shifter as the result.
    typedef struct packed {
        logic [1:0]        typ;
        logic              rrx;
        logic              cin;
        logic [DATA_W-1:0] op;
        logic [DATA_W:0]   coarse;
        logic [FW-1:0]     fine;
        logic              zero;   // amt == 0
        logic              lt;     // amt <  DATA_W
        logic              eq;     // amt == DATA_W
        logic              mod0;   // amt mod DATA_W == 0
        logic [TAG_W-1:0]  tag;
    } mid_t;

    function automatic logic [DATA_W-1:0] ror_w(input logic [DATA_W-1:0] x,
                                                input logic [LW-1:0] s);
        return DATA_W'({x, x} >> s);
    endfunction

    // Classify the amount and apply the coarse shift by amt[LW-1:FW].
    function automatic mid_t stage_a(input logic [1:0]        typ,
                                     input logic              rrx,
                                     input logic [AMT_W-1:0]  amt,
                                     input logic [DATA_W-1:0] op,
                                     input logic              cin,
                                     input logic [TAG_W-1:0]  tag);
        mid_t m;
        logic [LW-1:0] csh;
        logic signed [DATA_W:0] sx;
        csh    = {amt[LW-1:FW], {FW{1'b0}}};
        sx     = {op, 1'b0};
        m.typ  = typ;
        m.rrx  = rrx;
        m.cin  = cin;
        m.op   = op;
        m.fine = amt[FW-1:0];
        m.zero = (amt == '0);
        m.lt   = (amt < AMT_FULL);
        m.eq   = (amt == AMT_FULL);
        m.mod0 = (amt[LW-1:0] == '0);
        m.tag  = tag;
        case (typ)
            T_LSL:   m.coarse = {1'b0, op} << csh;
            T_LSR:   m.coarse = {op, 1'b0} >> csh;
            T_ASR:   m.coarse = sx >>> csh;
            default: m.coarse = {1'b0, ror_w(op, csh)};
        endcase
        return m;
    endfunction

    // Fine shift and final result/carry selection; returns {carry, result}.
    function automatic logic [DATA_W:0] stage_b(input mid_t m);
        logic [DATA_W:0]        ext;
        logic signed [DATA_W:0] sext;
        logic [DATA_W-1:0]      rot;
        logic [DATA_W-1:0]      res;
        logic                   c;
        res  = m.op;
        c    = m.cin;
        ext  = m.coarse << m.fine;
        sext = $signed(m.coarse) >>> m.fine;
        rot  = ror_w(m.coarse[DATA_W-1:0], LW'(m.fine));
        if (m.rrx) begin
            res = {m.cin, m.op[DATA_W-1:1]};
            c   = m.op[0];
        end else if (!m.zero) begin
            case (m.typ)
                T_LSL: begin
                    if (m.lt) begin
                        res = ext[DATA_W-1:0];
                        c   = ext[DATA_W];
                    end else begin
                        res = '0;
                        c   = m.eq & m.op[0];
                    end
                end
                T_LSR: begin
                    ext = m.coarse >> m.fine;
                    if (m.lt) begin
                        res = ext[DATA_W:1];
                        c   = ext[0];
                    end else begin
                        res = '0;
                        c   = m.eq & m.op[DATA_W-1];
                    end
                end
                T_ASR: begin
                    if (m.lt) begin
                        res = sext[DATA_W:1];
                        c   = sext[0];
                    end else begin
                        res = {DATA_W{m.op[DATA_W-1]}};
                        c   = m.op[DATA_W-1];
                    end
                end
                default: begin
                    if (m.mod0) begin
                        res = m.op;
                        c   = m.op[DATA_W-1];
                    end else begin
                        res = rot;
                        c   = rot[DATA_W-1];
                    end
                end
            endcase
        end
        return {c, res};
    endfunction

    // Front end: optional immediate decode, then coarse stage logic.
    logic [AMT_W-1:0] amt_eff;
    logic             rrx_eff;
    mid_t             front;

    always_comb begin
        amt_eff = in_amt;
        rrx_eff = in_rrx;
`ifdef SHIFT_IMM_DECODE_EN
        if (in_imm && !in_rrx) begin
            amt_eff = AMT_W'(in_amt[4:0]);
            if (in_amt[4:0] == 5'd0) begin
                case (in_type)
                    T_LSR, T_ASR: amt_eff = AMT_FULL;
                    T_ROR:        rrx_eff = 1'b1;
                    default:      amt_eff = '0;
                endcase
            end
        end
`endif
        front = stage_a(in_type, rrx_eff, amt_eff, in_op, in_carry, in_tag);
    end

    // Output register stage (shared by both pipeline depths).
    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_carry_q,  out_carry_d;
    logic [TAG_W-1:0]  out_tag_q,    out_tag_d;
    logic              ready_out;

    assign ready_out  = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_carry  = out_carry_q;
    assign out_tag    = out_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_carry_q  <= out_carry_d;
            out_tag_q    <= out_tag_d;
        end
    end

    if (PIPE == 1) begin : g_pipe1
        logic [DATA_W:0] res1;

        assign in_ready = ready_out;

        always_comb begin
            out_valid_d  = out_valid_q;
            out_result_d = out_result_q;
            out_carry_d  = out_carry_q;
            out_tag_d    = out_tag_q;
            res1         = stage_b(front);
            if (ready_out) begin
                out_valid_d = in_valid;
                if (in_valid && !flush) begin
                    out_result_d = res1[DATA_W-1:0];
                    out_carry_d  = res1[DATA_W];
                    out_tag_d    = front.tag;
                end
            end
            if (flush) begin
                out_valid_d = 1'b0;
            end
        end
    end else begin : g_pipe2
        logic            s1_valid_q, s1_valid_d;
        mid_t            s1_q, s1_d;
        logic            ready_s1;
        logic [DATA_W:0] res2;

        assign ready_s1 = !s1_valid_q || ready_out;
        assign in_ready = ready_s1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_q       <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_q       <= s1_d;
            end
        end

        always_comb begin
            s1_valid_d   = s1_valid_q;
            s1_d         = s1_q;
            out_valid_d  = out_valid_q;
            out_result_d = out_result_q;
            out_carry_d  = out_carry_q;
            out_tag_d    = out_tag_q;
            res2         = stage_b(s1_q);
            if (ready_out) begin
                out_valid_d = s1_valid_q;
                if (s1_valid_q && !flush) begin
                    out_result_d = res2[DATA_W-1:0];
                    out_carry_d  = res2[DATA_W];
                    out_tag_d    = s1_q.tag;
                end
            end
            if (ready_s1) begin
                s1_valid_d = in_valid;
                if (in_valid && !flush) begin
                    s1_d = front;
                end
            end
            if (flush) begin
                s1_valid_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        end
    end

endmodule
